// File: rtl/apb_xbar_tmo_pkg.sv
// Shared definitions for the registered APB3 1-to-N interconnect.
//   xbar_state_e : transfer sequencing states
//   ERR_*        : err_cause_o encodings (valid while err_o is high)
//   idx_width()  : width of a slave index for n slaves (never below 1)
package apb_xbar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } xbar_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DECODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_xbar_tmo_if.sv
// Bus bundle for apb_xbar_tmo: the upstream APB3 slave port (s_*) and the
// downstream fan-out to N_SLAVES peripherals (m_*).
//   modport slave  : the interconnect's view (answers s_*, drives m_*)
//   modport master : the environment's view (core-side master + peripherals)
interface apb_xbar_tmo_if #(
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned N_SLAVES       = 4
);
    logic [APB_ADDR_WIDTH-1:0]          s_paddr;
    logic                               s_psel;
    logic                               s_penable;
    logic                               s_pwrite;
    logic [APB_DATA_WIDTH-1:0]          s_pwdata;
    logic [APB_DATA_WIDTH-1:0]          s_prdata;
    logic                               s_pready;
    logic                               s_pslverr;

    logic [APB_ADDR_WIDTH-1:0]          m_paddr;
    logic [N_SLAVES-1:0]                m_psel;
    logic                               m_penable;
    logic                               m_pwrite;
    logic [APB_DATA_WIDTH-1:0]          m_pwdata;
    logic [N_SLAVES*APB_DATA_WIDTH-1:0] m_prdata;
    logic [N_SLAVES-1:0]                m_pready;
    logic [N_SLAVES-1:0]                m_pslverr;

    modport slave (
        input  s_paddr, s_psel, s_penable, s_pwrite, s_pwdata,
        output s_prdata, s_pready, s_pslverr,
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        input  m_prdata, m_pready, m_pslverr
    );

    modport master (
        output s_paddr, s_psel, s_penable, s_pwrite, s_pwdata,
        input  s_prdata, s_pready, s_pslverr,
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        output m_prdata, m_pready, m_pslverr
    );
endinterface

// File: rtl/apb_xbar_tmo_addr_decode.sv
// Combinational base-address decoder.
//   paddr : address to decode
//   hit   : some slave window contains paddr
//   idx   : index of the lowest-numbered matching slave (0 when !hit)
module apb_addr_decode
    import apb_xbar_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ACT_W    = 10,
    parameter int unsigned N_SLAVES = 4,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_W-1:0]              paddr,
    output logic                           hit,
    output logic [idx_width(N_SLAVES)-1:0] idx
);
    localparam int unsigned IDX_W = idx_width(N_SLAVES);
    localparam logic [ADDR_W-1:0] WIN_MASK = {ADDR_W{1'b1}} << ACT_W;

    // Ascending scan with a sticky hit gives lowest-index priority on overlap.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            if (!hit && ((paddr & WIN_MASK) == BASE_ADDR[k*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/apb_xbar_tmo.sv
// Registered 1-to-N APB3 interconnect with decode and timeout errors.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   bus          : upstream s_* and downstream m_* signals (slave modport)
//   err_o        : one-cycle pulse on a decode or timeout error
//   err_cause_o  : 01 decode, 10 timeout; valid with err_o
module apb_xbar_tmo
    import apb_xbar_pkg::*;
#(
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_ACT_ADDR_W = 10,
    parameter int unsigned N_SLAVES       = 4,
    parameter logic [N_SLAVES*APB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_xbar_tmo_if.slave  bus,
    output logic           err_o,
    output logic [1:0]     err_cause_o
);
    localparam int unsigned IDX_W = idx_width(N_SLAVES);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [APB_ADDR_WIDTH-1:0] OFS_MASK = ~({APB_ADDR_WIDTH{1'b1}} << APB_ACT_ADDR_W);

    xbar_state_e                state_q, state_d;
    logic                       dec_hit;
    logic [IDX_W-1:0]           dec_idx;
    logic [IDX_W-1:0]           idx_q;
    logic [APB_ADDR_WIDTH-1:0]  addr_q;
    logic [APB_DATA_WIDTH-1:0]  wdata_q;
    logic                       write_q;
    logic [APB_DATA_WIDTH-1:0]  rdata_q;
    logic                       slverr_q;
    logic                       tmo_q;
    logic [CNT_W-1:0]           cnt_q;

    logic                       capture, done, tmo_fire;
    logic                       sel_ready, sel_slverr;
    logic [APB_DATA_WIDTH-1:0]  sel_rdata;

    apb_addr_decode #(
        .ADDR_W    (APB_ADDR_WIDTH),
        .ACT_W     (APB_ACT_ADDR_W),
        .N_SLAVES  (N_SLAVES),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .paddr (bus.s_paddr),
        .hit   (dec_hit),
        .idx   (dec_idx)
    );

    always_comb begin
        sel_ready  = bus.m_pready[idx_q];
        sel_slverr = bus.m_pslverr[idx_q];
        sel_rdata  = bus.m_prdata[int'(idx_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        done     = 1'b0;
        tmo_fire = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.s_psel && !bus.s_penable) begin
                    capture = 1'b1;
                    state_d = dec_hit ? ST_SETUP : ST_ERR;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Ready on the limit cycle wins over the timeout.
                if (sel_ready) begin
                    done    = 1'b1;
                    state_d = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state, so they drop as soon as reset hits.
    always_comb begin
        bus.m_psel = '0;
        if (state_q == ST_SETUP || state_q == ST_ACCESS) bus.m_psel[idx_q] = 1'b1;
        bus.m_penable = (state_q == ST_ACCESS);
        bus.s_pready  = (state_q == ST_RESP) || (state_q == ST_ERR);
        bus.s_pslverr = (state_q == ST_ERR) || ((state_q == ST_RESP) && slverr_q);
        bus.s_prdata  = (state_q == ST_RESP) ? rdata_q : '0;
        err_o         = (state_q == ST_ERR) || ((state_q == ST_RESP) && tmo_q);
        err_cause_o   = ERR_NONE;
        if (state_q == ST_ERR)                err_cause_o = ERR_DECODE;
        else if (state_q == ST_RESP && tmo_q) err_cause_o = ERR_TIMEOUT;
    end

    assign bus.m_paddr  = addr_q;
    assign bus.m_pwrite = write_q;
    assign bus.m_pwdata = wdata_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idx_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (capture) begin
                idx_q   <= dec_idx;
                addr_q  <= bus.s_paddr & OFS_MASK;
                wdata_q <= bus.s_pwdata;
                write_q <= bus.s_pwrite;
            end
            if (state_q == ST_ACCESS && !sel_ready) cnt_q <= cnt_q + 1'b1;
            else                                    cnt_q <= '0;
            if (done) begin
                rdata_q  <= sel_rdata;
                slverr_q <= sel_slverr;
                tmo_q    <= 1'b0;
            end else if (tmo_fire) begin
                rdata_q  <= '0;
                slverr_q <= 1'b1;
                tmo_q    <= 1'b1;
            end
        end
    end
endmodule

// File: doc/apb_xbar_tmo.md
Name: apb_xbar_tmo

Overview:
- Parametrised 1-to-N APB3 interconnect. Successor to the single-cycle combinational APB bar.
- Decodes each upstream transfer against a per-slave base-address map.
- Registers the downstream SETUP/ACCESS sequence and the response path.
- Answers unmapped addresses with a decode error, and aborts hung slaves with a timeout error.
- Sits between the core-side APB master and the peripheral slaves.

Parameters:
- APB_DATA_WIDTH, 32, data bus width.
- APB_ADDR_WIDTH, 32, address bus width.
- APB_ACT_ADDR_W, 10, per-slave window is 2**APB_ACT_ADDR_W bytes; only these low bits are forwarded.
- N_SLAVES, 4, number of downstream slaves (1..16).
- BASE_ADDR, {N_SLAVES{32'h0}}, packed N_SLAVES*APB_ADDR_WIDTH base addresses; slave k occupies BASE_ADDR[k] .. BASE_ADDR[k]+2**APB_ACT_ADDR_W-1.
- TIMEOUT_CYCLES, 256, downstream ACCESS wait-state limit; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous reset, active-high.
- s_paddr  in  APB_ADDR_WIDTH  upstream address.
- s_psel  in  1  upstream select.
- s_penable  in  1  upstream enable.
- s_pwrite  in  1  upstream write.
- s_pwdata  in  APB_DATA_WIDTH  upstream write data.
- s_prdata  out  APB_DATA_WIDTH  upstream read data.
- s_pready  out  1  upstream ready.
- s_pslverr  out  1  upstream error.
- m_paddr  out  APB_ADDR_WIDTH  downstream address (offset only, upper bits zero).
- m_psel  out  N_SLAVES  one-hot downstream select.
- m_penable  out  1  downstream enable.
- m_pwrite  out  1  downstream write.
- m_pwdata  out  APB_DATA_WIDTH  downstream write data.
- m_prdata  in  N_SLAVES*APB_DATA_WIDTH  slave read data, slave k at slice k.
- m_pready  in  N_SLAVES  slave ready.
- m_pslverr  in  N_SLAVES  slave error.
- err_o  out  1  one-cycle pulse on a decode or timeout error.
- err_cause_o  out  2  cause, valid with err_o: 01 decode, 10 timeout.

Behaviour:
- Reset: asynchronous, active-high. FSM goes to IDLE. All outputs are 0, including m_psel, m_penable, s_pready, s_pslverr, s_prdata, err_o and err_cause_o. The timeout counter clears.
- Decode is combinational on s_paddr. Slave k hits when (s_paddr & ~(2**APB_ACT_ADDR_W-1)) == BASE_ADDR[k]. On overlapping windows the lowest index wins.
- On capture, the block latches addr offset, pwrite, pwdata and the slave index. Registered m_* outputs are driven from these latched values.
- FSM states: IDLE, SETUP, ACCESS, RESP, ERR.
- IDLE: on s_psel && !s_penable, capture the transfer. Go to SETUP on a hit, or to ERR on a miss.
- SETUP: m_psel[idx]=1, m_penable=0. Unconditionally go to ACCESS next cycle.
- ACCESS: m_psel[idx]=1, m_penable=1. On m_pready[idx]=1:
  - register s_prdata = m_prdata[idx] and s_pslverr = m_pslverr[idx];
  - drop m_psel and m_penable;
  - go to RESP.
- ACCESS timeout: the counter increments on each ACCESS cycle with m_pready[idx]=0. When it reaches TIMEOUT_CYCLES-1 with ready still low:
  - drop m_psel and m_penable;
  - set s_prdata=0, s_pslverr=1;
  - pulse err_o with cause 10;
  - go to RESP.
  - Ready arriving on the same cycle the limit is reached wins: normal completion, no error.
- ERR: s_pready=1, s_pslverr=1, s_prdata=0 for exactly one cycle; err_o pulses with cause 01; then go to IDLE. No downstream select is ever asserted for a miss.
- RESP: s_pready=1 for exactly one cycle with the registered data and error; then go to IDLE. s_prdata returns to 0 outside RESP and ERR.
- Latency, hit with zero slave wait states: upstream SETUP at cycle 0, downstream SETUP at 1, downstream ACCESS at 2, s_pready at 3.
- Latency, miss: s_pready at cycle 1.
- Upstream signals are ignored from capture until the response completes. If s_psel drops early, the downstream transfer still completes and the response is still driven.
- Back-to-back transfers: a new upstream SETUP is accepted in the cycle after RESP or ERR.
- m_pwdata and m_pwrite hold their captured values through SETUP and ACCESS.

Decomposition:
- Package apb_xbar_pkg holds the FSM state enum and the err_cause localparams ERR_NONE, ERR_DECODE, ERR_TIMEOUT.
- One sub-module, apb_addr_decode: purely combinational, takes paddr and outputs a hit flag plus the slave index. It is reused by future bridges.

Test Plan:
- Read from slave 2 (BASE=0x0000_0800, window 1 KiB) at 0x0804, zero wait states -> m_psel=4'b0100, m_paddr=0x004; s_pready at cycle 3 with the slave's 0xDEADBEEF; s_pslverr=0.
- Write to 0x0010 with slave 0 holding m_pready low for 5 cycles -> m_penable held for 6 cycles, m_pwdata stable; s_pready asserted 1 cycle after ready.
- Access to unmapped 0xFFFF_0000 -> m_psel stays 0; s_pready=s_pslverr=1 at cycle 1, s_prdata=0; err_o=1 with cause 01.
- TIMEOUT_CYCLES=8, slave never ready -> m_psel drops after 8 ACCESS cycles; s_pslverr=1; err_o with cause 10; the next transfer to another slave succeeds.
- PRESET asserted mid-ACCESS -> all outputs 0 immediately (asynchronous); after release, the FSM is IDLE and a fresh read completes normally.
- Slave returns m_pslverr=1 -> propagated to s_pslverr with no err_o pulse. A back-to-back read follows immediately and is accepted in the cycle after RESP.
